// File: rtl/regfile_wb_controller_pkg.sv
// Shared types for the register-file writeback controller: requester ids,
// the writeback request payload and the default data/index widths.
package regfile_pkg;

  localparam int unsigned BUS_W  = 8;
  localparam int unsigned ADDR_W = 3;

  // Requester identity; the value doubles as the round-robin pointer encoding.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  // One writeback request: destination register and the value to write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BUS_W-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_controller_if.sv
// Valid/ready writeback channel from one requester (ALU or LSU) into the
// controller. The requester is the master, the controller is the slave.
interface regfile_wb_controller_if;
  import regfile_pkg::*;

  logic    valid;
  logic    ready;
  wb_req_t req;

  modport master (output valid, output req, input ready);
  modport slave  (input valid, input req, output ready);

endinterface

// File: rtl/regfile_wb_controller_rr_arbiter2.sv
// Two-requester round-robin arbiter. A lone requester always wins; when both
// request, the pointer picks the winner and then moves to the loser.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,     // bit 0 = ALU, bit 1 = LSU
  output logic [1:0] grant_o,   // one-hot or zero
  output req_id_e    win_id_o
);

  req_id_e rr_ptr_q;
  req_id_e rr_ptr_d;

  // Grant decode: combinational so ready answers in the same cycle as valid.
  always_comb begin
    grant_o  = 2'b00;
    win_id_o = REQ_ALU;
    case (req_i)
      2'b01: begin
        grant_o  = 2'b01;
        win_id_o = REQ_ALU;
      end
      2'b10: begin
        grant_o  = 2'b10;
        win_id_o = REQ_LSU;
      end
      2'b11: begin
        if (rr_ptr_q == REQ_LSU) begin
          grant_o  = 2'b10;
          win_id_o = REQ_LSU;
        end else begin
          grant_o  = 2'b01;
          win_id_o = REQ_ALU;
        end
      end
      default: begin
        grant_o  = 2'b00;
        win_id_o = REQ_ALU;
      end
    endcase
  end

  // Pointer only moves on a contested grant; lone grants leave it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (req_i == 2'b11) begin
      if (rr_ptr_q == REQ_ALU) begin
        rr_ptr_d = REQ_LSU;
      end else begin
        rr_ptr_d = REQ_ALU;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= REQ_ALU;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_controller.sv
// Owns the register file's single write port (arbitrated between ALU and LSU)
// and its two synchronous read ports, forwarding the write that lands on the
// same edge as a read so readers never see the stale register value.
module regfile_wb_controller
  import regfile_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = BUS_W,
  parameter int unsigned ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_controller_if.slave alu_if,
  regfile_wb_controller_if.slave lsu_if,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr_o,
  output logic [BUS_WIDTH-1:0]  rf_wr_data_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b_i,
  input  logic [BUS_WIDTH-1:0]  rf_rd_data_a_i,
  input  logic [BUS_WIDTH-1:0]  rf_rd_data_b_i,
  output logic [BUS_WIDTH-1:0]  rd_data_a_o,
  output logic [BUS_WIDTH-1:0]  rd_data_b_o
);

  logic [1:0]            req_s;
  logic [1:0]            grant_s;
  req_id_e               win_id_s;
  wb_req_t               win_req_s;

  logic                  rf_we_q;
  logic [ADDR_WIDTH-1:0] rf_wr_addr_q;
  logic [BUS_WIDTH-1:0]  rf_wr_data_q;

  logic                  snap_we_q;
  logic [ADDR_WIDTH-1:0] snap_addr_q;
  logic [BUS_WIDTH-1:0]  snap_data_q;
  logic [ADDR_WIDTH-1:0] rd_addr_a_q;
  logic [ADDR_WIDTH-1:0] rd_addr_b_q;

  // Forwarding mux: the write that was on the port when the read address was
  // captured reaches the array on that same edge, so its data must override.
  function automatic logic [BUS_WIDTH-1:0] fwd_mux(
    input logic                  snap_we,
    input logic [ADDR_WIDTH-1:0] snap_addr,
    input logic [ADDR_WIDTH-1:0] rd_addr,
    input logic [BUS_WIDTH-1:0]  snap_data,
    input logic [BUS_WIDTH-1:0]  rf_data
  );
    logic [BUS_WIDTH-1:0] res;
    if (snap_we && (snap_addr == rd_addr)) begin
      res = snap_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  // Requests are masked while in reset so neither ready can rise.
  always_comb begin
    req_s = {lsu_if.valid & rst_n, alu_if.valid & rst_n};
  end

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_s),
    .grant_o  (grant_s),
    .win_id_o (win_id_s)
  );

  assign alu_if.ready = grant_s[0];
  assign lsu_if.ready = grant_s[1];

  // Select the winning requester's payload for the write stage.
  always_comb begin
    if (win_id_s == REQ_LSU) begin
      win_req_s = lsu_if.req;
    end else begin
      win_req_s = alu_if.req;
    end
  end

  // Write stage: a grant becomes a one-cycle write; addr/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q      <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else if (grant_s != 2'b00) begin
      rf_we_q      <= 1'b1;
      rf_wr_addr_q <= win_req_s.addr;
      rf_wr_data_q <= win_req_s.data;
    end else begin
      rf_we_q      <= 1'b0;
    end
  end

  // Snapshot of the write port alongside the read addresses it may collide with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_we_q   <= 1'b0;
      snap_addr_q <= '0;
      snap_data_q <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
    end else begin
      snap_we_q   <= rf_we_q;
      snap_addr_q <= rf_wr_addr_q;
      snap_data_q <= rf_wr_data_q;
      rd_addr_a_q <= rd_addr_a_i;
      rd_addr_b_q <= rd_addr_b_i;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_wr_addr_o = rf_wr_addr_q;
  assign rf_wr_data_o = rf_wr_data_q;

  assign rd_data_a_o = fwd_mux(snap_we_q, snap_addr_q, rd_addr_a_q, snap_data_q, rf_rd_data_a_i);
  assign rd_data_b_o = fwd_mux(snap_we_q, snap_addr_q, rd_addr_b_q, snap_data_q, rf_rd_data_b_i);

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Directed bench for regfile_wb_controller with a behavioural synchronous-read
// register file attached to the write and read ports.
module tb_regfile_wb_controller;
  import regfile_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rf_we;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic [2:0] rd_addr_a, rd_addr_b;
  logic [7:0] rf_rd_data_a, rf_rd_data_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       mem_clr;
  logic [7:0] mem [8];

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_controller_if alu_bus ();
  regfile_wb_controller_if lsu_bus ();

  regfile_wb_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_if         (alu_bus),
    .lsu_if         (lsu_bus),
    .rf_we_o        (rf_we),
    .rf_wr_addr_o   (rf_wr_addr),
    .rf_wr_data_o   (rf_wr_data),
    .rd_addr_a_i    (rd_addr_a),
    .rd_addr_b_i    (rd_addr_b),
    .rf_rd_data_a_i (rf_rd_data_a),
    .rf_rd_data_b_i (rf_rd_data_b),
    .rd_data_a_o    (rd_data_a),
    .rd_data_b_o    (rd_data_b)
  );

  always #5 clk = ~clk;

  // Register file model: write on the edge, registered read of the old value.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 8; k++) mem[k] <= 8'h00;
      rf_rd_data_a <= 8'h00;
      rf_rd_data_b <= 8'h00;
    end else begin
      if (rf_we) mem[rf_wr_addr] <= rf_wr_data;
      rf_rd_data_a <= mem[rd_addr_a];
      rf_rd_data_b <= mem[rd_addr_b];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [2:0] a, input logic [7:0] d);
    alu_bus.valid    = v;
    alu_bus.req.addr = a;
    alu_bus.req.data = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [2:0] a, input logic [7:0] d);
    lsu_bus.valid    = v;
    lsu_bus.req.addr = a;
    lsu_bus.req.data = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_clr   = 1'b1;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    drive_alu(1'b1, 3'd3, 8'h5A);
    drive_lsu(1'b1, 3'd2, 8'h22);
    tick();
    tick();
    // Reset state, with both valids high to show readies are held low.
    check_eq("rst_alu_ready", {31'd0, alu_bus.ready}, 32'd0);
    check_eq("rst_lsu_ready", {31'd0, lsu_bus.ready}, 32'd0);
    check_eq("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_eq("rst_wr_addr", {29'd0, rf_wr_addr}, 32'd0);
    check_eq("rst_wr_data", {24'd0, rf_wr_data}, 32'd0);
    check_eq("rst_rd_a", {24'd0, rd_data_a}, 32'd0);
    mem_clr = 1'b0;
    drive_alu(1'b0, 3'd0, 8'h00);
    drive_lsu(1'b0, 3'd0, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // ALU-only write of r3 = 0x5A.
    drive_alu(1'b1, 3'd3, 8'h5A);
    #1;
    check_eq("t1_alu_ready", {31'd0, alu_bus.ready}, 32'd1);
    check_eq("t1_lsu_ready", {31'd0, lsu_bus.ready}, 32'd0);
    tick();
    check_eq("t1_we", {31'd0, rf_we}, 32'd1);
    check_eq("t1_addr", {29'd0, rf_wr_addr}, 32'd3);
    check_eq("t1_data", {24'd0, rf_wr_data}, 32'h5A);
    drive_alu(1'b0, 3'd0, 8'h00);
    #1;
    check_eq("t1_alu_ready_off", {31'd0, alu_bus.ready}, 32'd0);
    tick();
    check_eq("t1_we_off", {31'd0, rf_we}, 32'd0);
    check_eq("t1_addr_hold", {29'd0, rf_wr_addr}, 32'd3);

    // Both valid for 4 cycles: grants alternate starting with the ALU.
    drive_alu(1'b1, 3'd1, 8'h11);
    drive_lsu(1'b1, 3'd2, 8'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t2_alu_ready", {31'd0, alu_bus.ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("t2_lsu_ready", {31'd0, lsu_bus.ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check_eq("t2_we", {31'd0, rf_we}, 32'd1);
      check_eq("t2_addr", {29'd0, rf_wr_addr}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check_eq("t2_data", {24'd0, rf_wr_data}, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    drive_alu(1'b0, 3'd0, 8'h00);
    drive_lsu(1'b0, 3'd0, 8'h00);
    tick();
    check_eq("t2_we_off", {31'd0, rf_we}, 32'd0);

    // Same-target conflict on r5: ALU first, LSU second, LSU value survives.
    drive_alu(1'b1, 3'd5, 8'hAA);
    drive_lsu(1'b1, 3'd5, 8'hBB);
    #1;
    check_eq("t3_alu_ready", {31'd0, alu_bus.ready}, 32'd1);
    check_eq("t3_lsu_ready", {31'd0, lsu_bus.ready}, 32'd0);
    tick();
    check_eq("t3_data1", {24'd0, rf_wr_data}, 32'hAA);
    drive_alu(1'b0, 3'd0, 8'h00);
    #1;
    check_eq("t3_lsu_ready2", {31'd0, lsu_bus.ready}, 32'd1);
    tick();
    check_eq("t3_we2", {31'd0, rf_we}, 32'd1);
    check_eq("t3_data2", {24'd0, rf_wr_data}, 32'hBB);
    drive_lsu(1'b0, 3'd0, 8'h00);
    tick();
    tick();
    rd_addr_a = 3'd5;
    tick();
    check_eq("t3_read_r5", {24'd0, rd_data_a}, 32'hBB);

    // Forwarding: r4 = 0x77 written in T+1 while both ports read r4.
    drive_alu(1'b1, 3'd4, 8'h77);
    #1;
    check_eq("t4_alu_ready", {31'd0, alu_bus.ready}, 32'd1);
    tick();
    drive_alu(1'b0, 3'd0, 8'h00);
    rd_addr_a = 3'd4;
    rd_addr_b = 3'd4;
    check_eq("t4_we", {31'd0, rf_we}, 32'd1);
    tick();
    check_eq("t4_fwd_a", {24'd0, rd_data_a}, 32'h77);
    check_eq("t4_fwd_b", {24'd0, rd_data_b}, 32'h77);
    rd_addr_b = 3'd1;
    tick();
    check_eq("t4_rf_a", {24'd0, rd_data_a}, 32'h77);
    check_eq("t4_rf_b_r1", {24'd0, rd_data_b}, 32'h11);
    // Write to r2 forwarded on port b only; port a on r4 must not pick it up.
    drive_lsu(1'b1, 3'd2, 8'h2C);
    #1;
    check_eq("t4_lsu_ready", {31'd0, lsu_bus.ready}, 32'd1);
    tick();
    drive_lsu(1'b0, 3'd0, 8'h00);
    rd_addr_a = 3'd4;
    rd_addr_b = 3'd2;
    tick();
    check_eq("t4_nofwd_a", {24'd0, rd_data_a}, 32'h77);
    check_eq("t4_fwd_b_r2", {24'd0, rd_data_b}, 32'h2C);

    // Reset mid-operation: prior r6 = 0x33, then an LSU write is dropped.
    drive_alu(1'b1, 3'd6, 8'h33);
    tick();
    drive_alu(1'b0, 3'd0, 8'h00);
    tick();
    tick();
    drive_lsu(1'b1, 3'd6, 8'h66);
    #1;
    check_eq("t5_lsu_ready", {31'd0, lsu_bus.ready}, 32'd1);
    rst_n = 1'b0;
    drive_lsu(1'b0, 3'd0, 8'h00);
    #1;
    check_eq("t5_rst_we", {31'd0, rf_we}, 32'd0);
    tick();
    check_eq("t5_rst_we2", {31'd0, rf_we}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t5_post_we", {31'd0, rf_we}, 32'd0);
    tick();
    check_eq("t5_post_we2", {31'd0, rf_we}, 32'd0);
    // Pointer was LSU before reset; after reset the ALU wins a contested cycle.
    drive_alu(1'b1, 3'd7, 8'h71);
    drive_lsu(1'b1, 3'd7, 8'h72);
    #1;
    check_eq("t5_ptr_alu", {31'd0, alu_bus.ready}, 32'd1);
    check_eq("t5_ptr_lsu", {31'd0, lsu_bus.ready}, 32'd0);
    tick();
    drive_alu(1'b0, 3'd0, 8'h00);
    drive_lsu(1'b0, 3'd0, 8'h00);
    check_eq("t5_we7", {31'd0, rf_we}, 32'd1);
    check_eq("t5_data7", {24'd0, rf_wr_data}, 32'h71);
    rd_addr_a = 3'd6;
    tick();
    check_eq("t5_read_r6", {24'd0, rd_data_a}, 32'h33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_controller.md
# regfile_wb_controller

Sequences the single write port of the CPU's general-purpose register file between two writeback requesters, the ALU and the load/store unit (LSU), using round-robin arbitration with valid/ready handshakes. It also owns the register file's two read ports. Because the register file's reads are synchronous, it forwards same-cycle write data so readers never observe a stale value. It sits between the execute/memory stages and the register file.

## Interface
- BUS_WIDTH, 8, register data width
- ADDR_WIDTH, 3, register index width (N = 2^ADDR_WIDTH registers)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  ADDR_WIDTH  ALU destination register
- alu_data  in  BUS_WIDTH  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_WIDTH  LSU destination register
- lsu_data  in  BUS_WIDTH  load result
- rf_we  out  1  register file write enable
- rf_wr_addr  out  ADDR_WIDTH  register file write address
- rf_wr_data  out  BUS_WIDTH  register file write data
- rd_addr_a, rd_addr_b  in  ADDR_WIDTH  reader addresses, passed straight through to the register file
- rf_rd_data_a, rf_rd_data_b  in  BUS_WIDTH  raw registered read data from the register file
- rd_data_a, rd_data_b  out  BUS_WIDTH  forwarded read data, valid one cycle after the address

## Operation
- Arbitration:
  - A transfer occurs when `x_valid && x_ready`.
  - `x_ready` is combinational from both valids and `rr_ptr`.
  - At most one ready is high per cycle, and a ready is never high without its own valid.
- `rr_ptr` (1 bit) selects the preferred requester: 0 = ALU, 1 = LSU.
  - Only one valid: that requester is granted regardless of `rr_ptr`.
  - Both valid: the preferred requester is granted, and `rr_ptr` moves to the other requester.
  - A single-requester grant leaves `rr_ptr` unchanged.
- Write stage: the granted addr/data are registered into `rf_wr_addr`/`rf_wr_data` with `rf_we` = 1 in the next cycle. With no grant, `rf_we` = 0 and the addr/data registers hold their values.
- Forwarding:
  - Each cycle, register `rd_addr_a`/`rd_addr_b` together with the current `rf_we`, `rf_wr_addr` and `rf_wr_data` (snapshot).
  - Next cycle, `rd_data_a` = snapshot data if the snapshot `we` is set and the snapshot addr equals the registered `rd_addr_a`; otherwise `rf_rd_data_a`.
  - Port b is handled identically and independently.
- Ordering: when both requesters target the same register in one cycle, both writes occur in arbitration order and the later one wins. The controller does not reorder or merge requests.

## Timing
- Reset values (async on `rst_n` low):
  - `rf_we` = 0, `rf_wr_addr` = 0, `rf_wr_data` = 0.
  - `rr_ptr` = 0.
  - Snapshot we/addr/data = 0; registered read addresses = 0.
  - `alu_ready` = `lsu_ready` = 0 while in reset.
- Reset asserted mid-operation: any registered write not yet performed is dropped, and no partial write is issued after release.
- Write latency: handshake in cycle T → `rf_we` high in T+1 → register file updated at the T+2 edge.
- Read latency: 1 cycle, same as the register file.
  - A read presented in T+1 to the register written in T+1 returns the new data via forwarding.
  - A read presented in T+2 or later returns it from the register file directly.
- Throughput: one write per cycle sustained.
- Fairness: with both valid continuously, grants strictly alternate, so worst-case wait is 1 cycle.
- Requesters hold valid/addr/data stable until ready; the controller does not check this.

## Structure
- Package `regfile_pkg`:
  - `req_id_e` enum (REQ_ALU = 0, REQ_LSU = 1).
  - `wb_req_t` struct {addr, data}, parameterised by localparams mirroring BUS_WIDTH/ADDR_WIDTH.
- Sub-module `rr_arbiter2`: two-requester round-robin arbiter holding `rr_ptr`, with outputs grant[1:0] and the winning id.
- The forwarding mux is instantiated once per read port inside `regfile_wb_controller`.

## Test plan
- Reset, then ALU-only: alu_valid, addr 3, data 0x5A for 1 cycle → `alu_ready` = 1 that cycle; `rf_we` = 1, `rf_wr_addr` = 3, `rf_wr_data` = 0x5A next cycle; then `rf_we` = 0.
- Both valid for 4 cycles (ALU addr 1 data 0x11, LSU addr 2 data 0x22) from reset → grants ALU, LSU, ALU, LSU; `rf_we` high for 4 consecutive cycles.
- Same-target conflict: both valid to addr 5 (ALU 0xAA, LSU 0xBB), `rr_ptr` = 0 → two writes; a later read of r5 returns 0xBB.
- Forwarding: write r4 = 0x77 in cycle T+1 while `rd_addr_a` = 4 and `rd_addr_b` = 4 in T+1 → `rd_data_a` = `rd_data_b` = 0x77 in T+2, even though `rf_rd_data` carries the old value.
- Reset mid-operation: grant LSU write to r6, assert `rst_n` low before `rf_we` cycle → `rf_we` stays 0, `rr_ptr` = 0; a later read of r6 shows its prior value.
